// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: forwarding muxes, load-use bubbles, branch flushes,
// multi-cycle E-op sequencing and data-memory wait/timeout. Perf counters under HAZ_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             mc_start_E,
  input  logic             mc_done,
  input  logic             mem_req_M,
  input  logic             mem_ack,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             mc_go,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MC_BUSY = 2'd2, ERR = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mc_go_q, mc_go_d;
  logic             bus_err_q, bus_err_d;
  logic             lw_stall, mem_hold;
  logic             run_like, allow_mc;

  always_comb begin
    ForwardA_E = 2'b00;
    if (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs1_E)      ForwardA_E = 2'b10;
    else if (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs1_E) ForwardA_E = 2'b01;
    ForwardB_E = 2'b00;
    if (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs2_E)      ForwardB_E = 2'b10;
    else if (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs2_E) ForwardB_E = 2'b01;
  end

  assign lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
  assign mem_hold = mem_req_M && !mem_ack;

  // Handshakes: mc_go is a one-cycle request; mc_done is a one-cycle completion
  // pulse; mem_ack completes the outstanding M-stage access in the cycle it is high.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mc_go_d    = 1'b0;
    bus_err_d  = bus_err_q;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0;
    run_like = 1'b0;
    allow_mc = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          {StallF, StallD, StallE, StallM} = 4'hf;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          run_like = 1'b1;
          allow_mc = 1'b1;
          if (mc_start_E) begin
            state_d = MC_BUSY;
            mc_go_d = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          run_like   = 1'b1;
          allow_mc   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          {StallF, StallD, StallE, StallM} = 4'hf;
          if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      MC_BUSY: begin
        if (mc_done) begin
          run_like = 1'b1;
          state_d  = RUN;
        end else begin
          {StallF, StallD, StallE} = 3'b111;
          FlushM = 1'b1;
        end
      end
      ERR: {StallF, StallD, StallE, StallM} = 4'hf;
      default: state_d = RUN;
    endcase
    // Shared RUN priority chain: multi-cycle start, then branch flush, then load-use
    if (run_like) begin
      if (allow_mc && mc_start_E) begin
        {StallF, StallD, StallE} = 3'b111;
        FlushM = 1'b1;
      end else if (PCSrc_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mc_go_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mc_go_q    <= mc_go_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mc_go     = mc_go_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + (StallF ? CNT_W'(1) : CNT_W'(0));
    flush_count_d  = flush_count_q + ((FlushD | FlushE | FlushM) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: combinational vector table in RUN plus
// hand-written memory-wait, multi-cycle, timeout and reset sequences.
module tb_hazard_sequencer;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic RegWrite_M, RegWrite_W, PCSrc_E, mc_start_E, mc_done, mem_req_M, mem_ack;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic mc_go, bus_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [1:0] dbg_state;
  logic [6:0] ctl;

  int n_vec = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  hazard_sequencer #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .ResultSrc_E(ResultSrc_E),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
    .mc_start_E(mc_start_E), .mc_done(mc_done), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .mc_go(mc_go), .bus_err(bus_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src;
    logic       rw_m, rw_w, pcsrc;
    logic [6:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    ResultSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0; PCSrc_E = 0;
    mc_start_E = 0; mc_done = 0; mem_req_M = 0; mem_ack = 0;
  endtask

  // check control outputs ahead of the edge, account the model counters, then cross the edge
  task automatic step(input string name, input logic [6:0] exp);
    #2;
    chk(name, {25'd0, ctl}, {25'd0, exp});
    if (exp[6]) exp_stall = exp_stall + 1;
    if (|exp[2:0]) exp_flush = exp_flush + 1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LW   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111000;
  localparam logic [6:0] C_MC   = 7'b1110001;

  initial begin
    //          rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w res  rwm  rww  pc   ctl     fa     fb
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00};
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, C_LW,   2'b00, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00};
    vecs[3]  = '{5'd1, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, C_LW,   2'b00, 2'b00};
    vecs[4]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00};
    vecs[5]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 2'b00, 1'b1, 1'b1, 1'b0, C_NONE, 2'b10, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b1, 1'b0, C_NONE, 2'b01, 2'b00};
    vecs[7]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 2'b00, 1'b0, 1'b1, 1'b0, C_NONE, 2'b01, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 5'd3, 5'd7, 5'd0, 5'd7, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, C_NONE, 2'b01, 2'b10};
    vecs[9]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd3, 5'd7, 2'b00, 1'b1, 1'b0, 1'b0, C_NONE, 2'b00, 2'b00};
    vecs[10] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, C_BR,   2'b00, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, C_BR,   2'b00, 2'b00};

    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_ctl", {25'd0, ctl}, 32'd0);
    chk("rst_mc_go", {31'd0, mc_go}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      clear_in();
      Rs1_D = vecs[i].rs1_d; Rs2_D = vecs[i].rs2_d; Rs1_E = vecs[i].rs1_e; Rs2_E = vecs[i].rs2_e;
      Rd_E = vecs[i].rd_e; Rd_M = vecs[i].rd_m; Rd_W = vecs[i].rd_w; ResultSrc_E = vecs[i].res_src;
      RegWrite_M = vecs[i].rw_m; RegWrite_W = vecs[i].rw_w; PCSrc_E = vecs[i].pcsrc;
      #1;
      chk($sformatf("vec%0d_fa", i), {30'd0, ForwardA_E}, {30'd0, vecs[i].exp_fa});
      chk($sformatf("vec%0d_fb", i), {30'd0, ForwardB_E}, {30'd0, vecs[i].exp_fb});
      step($sformatf("vec%0d_ctl", i), vecs[i].exp_ctl);
      chk($sformatf("vec%0d_state", i), {30'd0, dbg_state}, 32'd0);
    end
    clear_in();
    step("lw_release", C_NONE);

    // memory wait: three cycles without ack, released in the ack cycle
    mem_req_M = 1'b1;
    step("memw_0", C_MEM);
    chk("memw_state", {30'd0, dbg_state}, 32'd1);
    step("memw_1", C_MEM);
    step("memw_2", C_MEM);
    mem_ack = 1'b1;
    step("mem_ack", C_NONE);
    clear_in();
    chk("mem_back_run", {30'd0, dbg_state}, 32'd0);
    chk("mem_no_err", {31'd0, bus_err}, 32'd0);

    // multi-cycle op; a load-use hazard is visible only on the done cycle
    mc_start_E = 1'b1;
    #1;
    chk("mc_go_pre", {31'd0, mc_go}, 32'd0);
    step("mc_start", C_MC);
    chk("mc_go_pulse", {31'd0, mc_go}, 32'd1);
    chk("mc_state", {30'd0, dbg_state}, 32'd2);
    ResultSrc_E = 2'b01; Rd_E = 5'd9; Rs2_D = 5'd9;
    step("mc_busy_1", C_MC);
    chk("mc_go_once", {31'd0, mc_go}, 32'd0);
    step("mc_busy_2", C_MC);
    chk("mc_go_still0", {31'd0, mc_go}, 32'd0);
    mc_done = 1'b1;
    step("mc_done_lw", C_LW);
    clear_in();
    chk("mc_back_run", {30'd0, dbg_state}, 32'd0);
    chk("mc_go_after", {31'd0, mc_go}, 32'd0);
    step("mc_idle", C_NONE);

`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall", stall_cycles, exp_stall);
    chk("perf_flush", flush_count, exp_flush);
`else
    chk("perf_stall_tied", stall_cycles, 32'd0);
    chk("perf_flush_tied", flush_count, 32'd0);
`endif

    // timeout: count 1..4 in MEM_WAIT, ERR after the cycle that sees 4
    mem_req_M = 1'b1;
    step("tmo_0", C_MEM);
    step("tmo_1", C_MEM);
    step("tmo_2", C_MEM);
    step("tmo_3", C_MEM);
    chk("tmo_not_yet", {30'd0, dbg_state}, 32'd1);
    chk("tmo_err_low", {31'd0, bus_err}, 32'd0);
    step("tmo_4", C_MEM);
    chk("tmo_err_state", {30'd0, dbg_state}, 32'd3);
    chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    clear_in();
    step("err_hold_0", C_MEM);
    mem_ack = 1'b1;
    step("err_hold_1", C_MEM);
    chk("err_sticky", {31'd0, bus_err}, 32'd1);
    clear_in();

    // asynchronous reset away from the clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    chk("arst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("arst_ctl", {25'd0, ctl}, 32'd0);
    chk("arst_stall_cnt", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", C_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
